// File: rtl/oled_task_scheduler.sv
// Picks one of four OLED tasks from the request switches, blanks the panel for a few
// frames between tasks, and forwards a debounced centre-button press to the running task.
//
//   state  | meaning
//   IDLE   | no task requested; all tasks held in reset, panel black
//   SWITCH | new task chosen; panel black until SWITCH_FRAMES frames have started
//   RUN    | active task out of reset, its pixels forwarded, button presses delivered
module oled_task_scheduler #(
   parameter int DEBOUNCE_CYCLES = 62500,
   parameter int TICK_DIV        = 138889,
   parameter int SWITCH_FRAMES   = 2
) (
   input  logic        clk_mhz_6_25,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic        btn_raw,
   input  logic        frame_begin,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   input  logic [15:0] data2,
   input  logic [15:0] data3,
   output logic [15:0] oled_data,
   output logic [3:0]  task_reset,
   output logic [3:0]  task_btn,
   output logic        tick_45,
   output logic [1:0]  active_idx,
   output logic        active_valid
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TICK_W  = $clog2(TICK_DIV + 1);
   localparam int FRAME_W = $clog2(SWITCH_FRAMES + 1);

   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SWITCH_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWITCH = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [1:0]         idx_nxt;
   logic [FRAME_W-1:0] frame_cnt;
   logic [FRAME_W-1:0] frame_cnt_nxt;
   logic               has_target;
   logic [1:0]         target;
   logic               run_nxt;
   logic               stay_run;
   logic [15:0]        data_sel;

   logic [TICK_W-1:0]  tick_cnt;
   logic               sync1;
   logic               sync2;
   logic               db_level;
   logic [DB_W-1:0]    db_cnt;
   logic               db_rise;
   logic               pending;

   // Lowest set request bit wins.
   always_comb begin
      has_target = |req;
      target     = 2'd0;
      if (req[0])      target = 2'd0;
      else if (req[1]) target = 2'd1;
      else if (req[2]) target = 2'd2;
      else if (req[3]) target = 2'd3;
   end

   always_ff @(posedge clk_mhz_6_25) begin
      if (reset) begin
         state      <= IDLE;
         active_idx <= 2'd0;
         frame_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         active_idx <= idx_nxt;
         frame_cnt  <= frame_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = active_idx;
      frame_cnt_nxt = frame_cnt;
      case (state)
         IDLE: begin
            if (has_target) begin
               state_nxt     = SWITCH;
               idx_nxt       = target;
               frame_cnt_nxt = '0;
            end
         end
         SWITCH, RUN: begin
            if (!has_target) begin
               state_nxt = IDLE;
            end else if (target != active_idx) begin
               state_nxt     = SWITCH;
               idx_nxt       = target;
               frame_cnt_nxt = '0;
            end else if (state == SWITCH && frame_begin) begin
               if (frame_cnt == FRAME_LAST) state_nxt = RUN;
               else                         frame_cnt_nxt = frame_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign run_nxt      = (state_nxt == RUN);
   assign stay_run     = (state == RUN) && run_nxt;
   assign active_valid = (state == RUN);

   always_comb begin
      data_sel = data0;
      case (active_idx)
         2'd0: data_sel = data0;
         2'd1: data_sel = data1;
         2'd2: data_sel = data2;
         2'd3: data_sel = data3;
         default: data_sel = data0;
      endcase
   end

   // Outputs are driven from the next state so the panel and task resets change
   // on the same edge as the state itself.
   always_ff @(posedge clk_mhz_6_25) begin
      if (reset) begin
         oled_data  <= 16'h0000;
         task_reset <= 4'b1111;
      end else begin
         oled_data  <= stay_run ? data_sel : 16'h0000;
         task_reset <= run_nxt ? ~(4'b0001 << idx_nxt) : 4'b1111;
      end
   end

   always_ff @(posedge clk_mhz_6_25) begin
      if (reset)                   tick_cnt <= '0;
      else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                         tick_cnt <= tick_cnt + 1'b1;
   end

   assign tick_45 = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk_mhz_6_25) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         if (sync2 != db_level) begin
            if (db_cnt == DB_LAST) begin
               db_level <= sync2;
               db_cnt   <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign db_rise = sync2 && !db_level && (db_cnt == DB_LAST);

   // An edge landing on the tick itself is kept for the following tick.
   always_ff @(posedge clk_mhz_6_25) begin
      if (reset) begin
         pending  <= 1'b0;
         task_btn <= 4'b0000;
      end else if (!stay_run) begin
         pending  <= 1'b0;
         task_btn <= 4'b0000;
      end else if (tick_45) begin
         task_btn <= pending ? (4'b0001 << active_idx) : 4'b0000;
         pending  <= db_rise;
      end else begin
         pending <= pending | db_rise;
      end
   end

endmodule
